// File: rtl/hack_pkg.sv
// hack_pkg: shared widths, FSM state encoding and jump-bit positions for the
// Hack program-counter unit. HALT_DETECT_EN adds the HALT state to the enum.
package hack_pkg;

    // Program counter / ROM address width.
    localparam int PC_W = 15;

    // Bit positions of the jump field (instruction[2:0]).
    localparam int JBIT_LT = 2;
    localparam int JBIT_EQ = 1;
    localparam int JBIT_GT = 0;

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } pc_state_e;
`endif

endpackage

// File: rtl/jump_cond.sv
// jump_cond: combinational Hack jump evaluation from the jump bits and ALU flags.
// A-instructions never jump; zr=1 with ng=1 is evaluated literally.
module jump_cond
    import hack_pkg::*;
(
    input  logic       is_c_instr,
    input  logic [2:0] jbits,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    // Any enabled comparison that matches the flags selects the jump target.
    always_comb begin
        jump = is_c_instr & ((jbits[JBIT_LT] & ng) |
                             (jbits[JBIT_EQ] & zr) |
                             (jbits[JBIT_GT] & ~ng & ~zr));
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: Hack CPU program counter and instruction-fetch sequencer.
// IDLE waits for run, FETCH handshakes with the ROM, EXEC waits for the CPU to
// finish the instruction and then advances or jumps.
// Build macro HALT_DETECT_EN: a taken self-jump parks the unit in HALT and
// raises `halted`; without it the self-jump simply refetches forever.
module pc_unit
    import hack_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            rom_req,
    output logic [PC_W-1:0] rom_addr,
    input  logic            rom_ack,
    output logic            fetch_ready,
    input  logic            instr_valid,
    input  logic            is_c_instr,
    input  logic [2:0]      jbits,
    input  logic [PC_W-1:0] a_reg,
    input  logic            zr,
`ifdef HALT_DETECT_EN
    input  logic            ng,
    output logic            halted
`else
    input  logic            ng
`endif
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            jump;

    jump_cond u_jump_cond (
        .is_c_instr (is_c_instr),
        .jbits      (jbits),
        .zr         (zr),
        .ng         (ng),
        .jump       (jump)
    );

    // Sequential increment wraps naturally at the 15-bit boundary.
    assign pc_inc   = pc_q + PC_W'(1);
    assign rom_addr = pc_q;

`ifdef HALT_DETECT_EN
    assign halted = (state_q == ST_HALT);
`endif

    // State and PC registers; reset abandons any outstanding fetch.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, next-PC and Moore outputs; rom_ack/instr_valid only matter in their own states.
    // NOTE: every output is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rom_req     = 1'b0;
        fetch_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                fetch_ready = 1'b1;
                if (instr_valid) begin
`ifdef HALT_DETECT_EN
                    if (jump && (a_reg == pc_q)) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = jump ? a_reg : pc_inc;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = jump ? a_reg : pc_inc;
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef HALT_DETECT_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized scoreboard bench for pc_unit. The driver pushes the
// address it expects the next fetch to use; a negedge monitor pops and compares
// whenever a new ROM request appears. Honours HALT_DETECT_EN like the RTL.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        run;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_ack;
    logic        fetch_ready;
    logic        instr_valid;
    logic        is_c_instr;
    logic [2:0]  jbits;
    logic [14:0] a_reg;
    logic        zr;
    logic        ng;
`ifdef HALT_DETECT_EN
    logic        halted;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [14:0] exp_q[$];
    logic [14:0] model_pc;
    logic [14:0] held_addr;
    logic        prev_req;

    pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .is_c_instr  (is_c_instr),
        .jbits       (jbits),
        .a_reg       (a_reg),
        .zr          (zr),
`ifdef HALT_DETECT_EN
        .ng          (ng),
        .halted      (halted)
`else
        .ng          (ng)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the flags describe the ALU result as negative, zero or
    // positive; a C-instruction jumps when its jump field enables that outcome.
    function automatic logic model_jump(input logic c, input logic [2:0] j,
                                        input logic z, input logic n);
        logic lt_ok, eq_ok, gt_ok;
        lt_ok = j[2] && n;
        eq_ok = j[1] && z;
        gt_ok = j[0] && !n && !z;
        return c && (lt_ok || eq_ok || gt_ok);
    endfunction

    // Monitor: every new fetch request must carry the next expected address.
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (rom_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_fetch: fetch at 0x%0h, expected no fetch", rom_addr);
                end else begin
                    held_addr = exp_q.pop_front();
                    check("fetch_addr", {17'd0, rom_addr}, {17'd0, held_addr});
                end
            end else if (rom_req) begin
                check("fetch_addr_stable", {17'd0, rom_addr}, {17'd0, held_addr});
            end
            if (rom_req && fetch_ready) check("req_ready_exclusive", 32'd1, 32'd0);
            prev_req = rom_req;
        end
    end

    // Wait for a request, hold off for wait_n cycles (with instr_valid noise), then ack.
    task automatic ack_fetch(input int wait_n);
        int guard = 0;
        while (!rom_req && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rom_req) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: rom_req=0 after 50 cycles, expected 1");
            return;
        end
        for (int i = 0; i < wait_n; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            is_c_instr  = 1'b1;
            jbits       = 3'b111;
            a_reg       = 15'($urandom);
            @(posedge clk); #1;
            check("req_held_until_ack", rom_req, 1);
        end
        rom_ack = 1'b1;
        @(posedge clk); #1;
        rom_ack     = 1'b0;
        instr_valid = 1'b0;
        check("fetch_ready_after_ack", fetch_ready, 1);
        check("req_dropped_after_ack", rom_req, 0);
    endtask

    // Hold EXEC for hold_n cycles (with rom_ack noise), then complete an instruction.
    task automatic exec_instr(input logic c, input logic [2:0] j, input logic [14:0] a,
                              input logic z, input logic n, input int hold_n);
        logic        jmp;
        logic [14:0] nxt;
        for (int i = 0; i < hold_n; i++) begin
            instr_valid = 1'b0;
            rom_ack     = 1'($urandom_range(0, 1));
            is_c_instr  = 1'($urandom);
            jbits       = 3'($urandom);
            a_reg       = 15'($urandom);
            @(posedge clk); #1;
            check("exec_hold_ready", fetch_ready, 1);
            check("exec_hold_pc", {17'd0, rom_addr}, {17'd0, model_pc});
        end
        rom_ack     = 1'b0;
        is_c_instr  = c;
        jbits       = j;
        a_reg       = a;
        zr          = z;
        ng          = n;
        instr_valid = 1'b1;
        jmp = model_jump(c, j, z, n);
        nxt = jmp ? a : 15'((32'(model_pc) + 1) % 32768);
`ifdef HALT_DETECT_EN
        if (!(jmp && a == model_pc)) exp_q.push_back(nxt);
`else
        exp_q.push_back(nxt);
`endif
        model_pc = nxt;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    // Move the PC to target via an unconditional jump (from FETCH state).
    task automatic set_pc(input logic [14:0] target);
        if (model_pc == target) begin
            ack_fetch(0);
            exec_instr(1'b1, 3'b111, target ^ 15'd1, 1'b0, 1'b0, 0);
        end
        ack_fetch(0);
        exec_instr(1'b1, 3'b111, target, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        logic [2:0] zn;
        reset = 1'b1; run = 1'b0; rom_ack = 1'b0; instr_valid = 1'b0;
        is_c_instr = 1'b0; jbits = 3'b000; a_reg = 15'd0; zr = 1'b0; ng = 1'b0;
        model_pc = 15'd0; prev_req = 1'b0; held_addr = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rom_req", rom_req, 0);
        check("reset_fetch_ready", fetch_ready, 0);
        check("reset_pc", {17'd0, rom_addr}, 0);
`ifdef HALT_DETECT_EN
        check("reset_halted", halted, 0);
`endif
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_req", rom_req, 0);
        check("idle_no_ready", fetch_ready, 0);

        // First fetch: ack after two wait cycles -> three request cycles.
        exp_q.push_back(15'd0);
        run = 1'b1;
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            run = 1'b0;
            if (rom_req && rom_addr == 15'd0) req_cycles++;
            if (i == 2) rom_ack = 1'b1;
        end
        check("first_fetch_req_cycles", req_cycles, 3);
        @(posedge clk); #1;
        rom_ack = 1'b0;
        check("first_fetch_ready", fetch_ready, 1);
        check("first_fetch_req_drop", rom_req, 0);

        // Sequential step from 0, then wrap at 0x7FFF (run already low).
        exec_instr(1'b0, 3'b111, 15'h1234, 1'b0, 1'b0, 2);
        set_pc(15'h7FFF);
        ack_fetch(1);
        exec_instr(1'b0, 3'($urandom), 15'($urandom), 1'b0, 1'b1, 1);

        // Jump table: every jump field against zero, negative, positive and zr&ng.
        for (int j = 0; j < 8; j++) begin
            for (int f = 0; f < 4; f++) begin
                zn = (f == 0) ? 3'b010 : (f == 1) ? 3'b001 : (f == 2) ? 3'b000 : 3'b011;
                set_pc(15'h0010);
                ack_fetch(j % 3);
                exec_instr(1'b1, 3'(j), 15'h0100, zn[1], zn[0], f % 2);
            end
        end

        // A-instruction with every jump bit set never jumps.
        set_pc(15'h0010);
        ack_fetch(0);
        exec_instr(1'b0, 3'b111, 15'h0200, 1'b0, 1'b0, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic [14:0] a;
            a = 15'($urandom);
            if (a == model_pc) a = a ^ 15'd1;
            ack_fetch($urandom_range(0, 3));
            exec_instr(1'($urandom), 3'($urandom), a, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3));
        end

        // Reset in the middle of a fetch; a late ack must be ignored.
        set_pc(15'h0123);
        @(posedge clk); #1;
        check("mid_fetch_req", rom_req, 1);
        reset = 1'b1;
        #1;
        check("async_reset_req", rom_req, 0);
        check("async_reset_pc", {17'd0, rom_addr}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_pc = 15'd0;
        rom_ack = 1'b1;
        @(posedge clk); #1;
        rom_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle_req", rom_req, 0);
            check("post_reset_no_exec", fetch_ready, 0);
            check("post_reset_pc", {17'd0, rom_addr}, 0);
        end

        // Self-jump at 0x0005.
        exp_q.push_back(15'd0);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        set_pc(15'h0005);
        ack_fetch(0);
        exec_instr(1'b1, 3'b111, 15'h0005, 1'b0, 1'b0, 0);
`ifdef HALT_DETECT_EN
        for (int i = 0; i < 20; i++) begin
            check("halt_halted", halted, 1);
            check("halt_no_req", rom_req, 0);
            check("halt_no_ready", fetch_ready, 0);
            check("halt_pc", {17'd0, rom_addr}, 32'h5);
            rom_ack = 1'($urandom); instr_valid = 1'($urandom);
            @(posedge clk); #1;
        end
        rom_ack = 1'b0; instr_valid = 1'b0;
`else
        for (int i = 0; i < 3; i++) begin
            ack_fetch(1);
            exec_instr(1'b1, 3'b111, 15'h0005, 1'b0, 1'b0, 0);
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL use a single clock `clk`, and its reset `reset` SHALL be asynchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `run`: input, 1 bit, start enable, sampled in IDLE.
REQ-005 Port `rom_req`: output, 1 bit, instruction-fetch request.
REQ-006 Port `rom_addr`: output, 15 bits, fetch address; this is the current PC.
REQ-007 Port `rom_ack`: input, 1 bit, ROM data-valid for the outstanding request.
REQ-008 Port `fetch_ready`: output, 1 bit, fetched instruction is available to the CPU.
REQ-009 Port `instr_valid`: input, 1 bit, CPU has executed the current instruction; flags and operands are valid.
REQ-010 Port `is_c_instr`: input, 1 bit, instruction[15].
REQ-011 Port `jbits`: input, 3 bits, instruction[2:0] (bit2 = lt, bit1 = eq, bit0 = gt).
REQ-012 Port `a_reg`: input, 15 bits, jump target (A register[14:0]).
REQ-013 Ports `zr` and `ng`: input, 1 bit each, ALU zero and negative flags.
REQ-014 Port `halted`: output, 1 bit, tight-loop halt detected; present only when HALT_DETECT_EN is defined.

Function
REQ-015 The FSM SHALL have these states: IDLE, FETCH, EXEC, plus HALT when HALT_DETECT_EN is defined.
REQ-016 IDLE SHALL move to FETCH on the first clock edge with run=1; while in IDLE, rom_req=0 and fetch_ready=0.
REQ-017 In FETCH, rom_req SHALL be 1 and rom_addr=pc, held stable until rom_ack=1.
REQ-018 rom_ack=1 in FETCH SHALL cause a transition to EXEC on the next edge; rom_req SHALL drop in the same edge.
REQ-019 rom_ack SHALL be ignored outside FETCH.
REQ-020 Fetch latency SHALL be: rom_req asserted in the cycle after entering FETCH, with a minimum of 1 cycle from ack to fetch_ready.
REQ-021 In EXEC, fetch_ready SHALL be 1; with instr_valid=0 the block SHALL hold pc and state.
REQ-022 instr_valid SHALL be ignored outside EXEC.
REQ-023 The jump condition SHALL be: jump = is_c_instr & ((jbits[2]&ng) | (jbits[1]&zr) | (jbits[0]&~ng&~zr)).
REQ-024 On instr_valid=1 in EXEC: pc ← a_reg if jump, else pc+1 modulo 2^15 (0x7FFF wraps to 0x0000); state → FETCH.
REQ-025 An A-instruction (is_c_instr=0) SHALL never jump, regardless of jbits.
REQ-026 The flag combination zr=1 with ng=1 SHALL be evaluated literally per REQ-023, with no filtering.
REQ-027 The `run` input SHALL be sampled only in IDLE; deasserting it later SHALL NOT stop execution.

Reset
REQ-028 Asserting reset SHALL immediately force: state=IDLE, pc=0x0000, rom_req=0, fetch_ready=0, halted=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request; a late rom_ack SHALL be ignored per REQ-019.
REQ-030 After reset releases, operation SHALL resume from IDLE only.

Configuration
REQ-031 The feature SHALL be controlled by macro HALT_DETECT_EN.
REQ-032 With HALT_DETECT_EN defined: when a taken jump in EXEC has a_reg == pc, the block SHALL enter HALT instead of FETCH; pc is unchanged, rom_req=0, fetch_ready=0, halted=1; HALT SHALL be left only by reset.
REQ-033 With HALT_DETECT_EN undefined: the `halted` port and the HALT state SHALL be absent, and a self-jump SHALL refetch indefinitely.

Structure
REQ-034 Shared package hack_pkg SHALL hold: PC_W=15, the FSM state enum, and the JBIT_LT/JBIT_EQ/JBIT_GT index constants.
REQ-035 The jump evaluation of REQ-023 SHALL be a combinational sub-module `jump_cond` (inputs jbits, zr, ng, is_c_instr; output jump).

Verification
REQ-036 Reset, run=1, ack after 2 wait cycles -> rom_req held 3 cycles at addr 0x0000, fetch_ready=1 the next cycle.
REQ-037 Sequential flow: pc=0x7FFF, A-instruction, instr_valid=1 -> next fetch at rom_addr=0x0000.
REQ-038 Jump table: for each jbits 000..111 × flags {zr, ng, positive}, with a_reg=0x0100 and pc=0x0010 -> fetch at 0x0100 iff the REQ-023 condition holds, else 0x0011.
REQ-039 is_c_instr=0, jbits=111, a_reg=0x0200 -> next fetch at pc+1.
REQ-040 HALT_DETECT_EN defined, pc=0x0005, a_reg=0x0005, jbits=111 -> halted=1 and rom_req stays 0 for 20 cycles; undefined -> repeated fetches at 0x0005.
REQ-041 Reset pulsed while rom_req=1, then rom_ack pulsed after release -> state IDLE, pc=0, no transition to EXEC.
